fsm_state_trigger_monitor: RTL and testbench

//  Custom acquisition trigger watching an encoded FSM state bus (e.g. the AES core state) on acq_clk.

---
 rtl/fsm_state_trigger_monitor.sv | 103 ++++++++++
 tb/tb_fsm_state_trigger_monitor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fsm_state_trigger_monitor.sv
// Trigger monitor for an encoded FSM state bus: range, X/Z, dwell and transition checks.
// Drives a logic-analyser trigger with cause, offending code and a saturating fault count.
module fsm_state_trigger_monitor #(
  parameter int unsigned STATE_W     = 4,
  parameter int unsigned MAX_STATE   = 9,
  parameter int unsigned IDLE_STATE  = 0,
  parameter int unsigned WATCH_STATE = 6,
  parameter int unsigned DWELL_LIMIT = 12,
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned EVT_W       = 8,
  parameter int unsigned CHECK_SEQ   = 1,
  parameter int unsigned STICKY      = 1
) (
  input  logic               acq_clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic [STATE_W-1:0] data_in,
  output logic               trigger_out,
  output logic [3:0]         cause,
  output logic [STATE_W-1:0] trig_state,
  output logic [EVT_W-1:0]   event_count
);

  localparam logic [STATE_W-1:0] MaxCode   = STATE_W'(MAX_STATE);
  localparam logic [STATE_W-1:0] IdleCode  = STATE_W'(IDLE_STATE);
  localparam logic [STATE_W-1:0] WatchCode = STATE_W'(WATCH_STATE);
  localparam logic [CNT_W:0]     Limit     = (CNT_W + 1)'(DWELL_LIMIT);

  logic [STATE_W-1:0] prev_state;
  logic               prev_valid;
  logic [CNT_W-1:0]   run;

  logic               xz_in, xz_prev;
  logic               in_watch, seq_ok;
  logic [CNT_W:0]     run_next;
  logic [3:0]         f;
  logic [3:0]         cause_base, cause_d;
  logic               trigger_d, load_state;
  logic [STATE_W-1:0] trig_state_d;
  logic [CNT_W-1:0]   run_d;
  logic [EVT_W-1:0]   cnt_base, event_count_d;

`ifndef SYNTHESIS
  // Unknown codes must not poison the other checks or the stored state.
  assign xz_in   = $isunknown(data_in);
  assign xz_prev = $isunknown(prev_state);
`else
  assign xz_in   = 1'b0;
  assign xz_prev = 1'b0;
`endif

  always_comb begin
    in_watch = !xz_in && (data_in == WatchCode);
    run_next = in_watch ? ({1'b0, run} + (CNT_W + 1)'(1)) : '0;
    run_d    = in_watch ? ((&run) ? run : run + CNT_W'(1)) : '0;

    // Successor compare is one bit wider so the top code has no wrap-around successor.
    seq_ok = (data_in == prev_state) || (data_in == IdleCode) ||
             ({1'b0, data_in} == ({1'b0, prev_state} + (STATE_W + 1)'(1)));

    f    = '0;
    f[0] = !xz_in && (data_in > MaxCode);
    f[1] = xz_in;
    f[2] = run_next > Limit;
    f[3] = (CHECK_SEQ != 0) && prev_valid && !f[0] && !f[1] && !xz_prev && !seq_ok;

    cause_base = clear ? 4'b0 : cause;
    if (STICKY != 0) begin
      cause_d    = cause_base | f;
      trigger_d  = |cause_d;
      load_state = (|f) && (clear || (cause == 4'b0));
    end else begin
      cause_d    = f;
      trigger_d  = |f;
      load_state = |f;
    end
    trig_state_d = load_state ? data_in : (clear ? '0 : trig_state);

    cnt_base      = clear ? '0 : event_count;
    event_count_d = ((|f) && !(&cnt_base)) ? cnt_base + EVT_W'(1) : cnt_base;
  end

  always_ff @(posedge acq_clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_state  <= '0;
      prev_valid  <= 1'b0;
      run         <= '0;
      trigger_out <= 1'b0;
      cause       <= 4'b0;
      trig_state  <= '0;
      event_count <= '0;
    end else begin
      prev_state  <= data_in;
      prev_valid  <= 1'b1;
      run         <= run_d;
      trigger_out <= trigger_d;
      cause       <= cause_d;
      trig_state  <= trig_state_d;
      event_count <= event_count_d;
    end
  end

endmodule

// File: tb/tb_fsm_state_trigger_monitor.sv
// Directed bench: a sticky and a pulse-mode monitor share one stimulus stream.
module tb_fsm_state_trigger_monitor;

  logic       acq_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear   = 1'b0;
  logic [3:0] data_in = 4'h0;

  logic       s_trig, p_trig;
  logic [3:0] s_cause, p_cause;
  logic [3:0] s_state, p_state;
  logic [7:0] s_cnt, p_cnt;

  int errors = 0;
  int checks = 0;

  always #5 acq_clk = ~acq_clk;

  fsm_state_trigger_monitor #(.STICKY(1)) u_s (
    .acq_clk     (acq_clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .data_in     (data_in),
    .trigger_out (s_trig),
    .cause       (s_cause),
    .trig_state  (s_state),
    .event_count (s_cnt)
  );

  fsm_state_trigger_monitor #(.STICKY(0)) u_p (
    .acq_clk     (acq_clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .data_in     (data_in),
    .trigger_out (p_trig),
    .cause       (p_cause),
    .trig_state  (p_state),
    .event_count (p_cnt)
  );

  task automatic apply(input logic [3:0] d);
    data_in = d;
    @(posedge acq_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge acq_clk);
    reset_n = 1'b0;
    clear   = 1'b0;
    data_in = 4'h0;
    @(negedge acq_clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (s_trig !== 1'b0) begin errors++; $display("FAIL reset_trig got=%b exp=0", s_trig); end
    checks++; if (s_cause !== 4'b0) begin errors++; $display("FAIL reset_cause got=%b exp=0000", s_cause); end
    checks++; if (s_state !== 4'h0) begin errors++; $display("FAIL reset_state got=%h exp=0", s_state); end
    checks++; if (s_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", s_cnt); end
    checks++; if (p_trig !== 1'b0) begin errors++; $display("FAIL reset_ptrig got=%b exp=0", p_trig); end
  endtask

  task automatic test_legal_walk();
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      apply((i == 10) ? 4'h0 : 4'(i));
      checks++;
      if (s_trig !== 1'b0 || s_cause !== 4'b0) begin
        errors++; $display("FAIL walk_%0d trig=%b cause=%b exp 0/0000", i, s_trig, s_cause);
      end
    end
    checks++; if (s_cnt !== 8'd0) begin errors++; $display("FAIL walk_cnt got=%0d exp=0", s_cnt); end
  endtask

  task automatic test_range();
    do_reset();
    for (int i = 0; i < 4; i++) apply(4'(i));
    apply(4'hA);
    checks++; if (s_cause !== 4'b0001) begin errors++; $display("FAIL range_cause got=%b exp=0001", s_cause); end
    checks++; if (s_state !== 4'hA) begin errors++; $display("FAIL range_state got=%h exp=a", s_state); end
    checks++; if (s_cnt !== 8'd1) begin errors++; $display("FAIL range_cnt got=%0d exp=1", s_cnt); end
    checks++; if (p_trig !== 1'b1) begin errors++; $display("FAIL range_ptrig got=%b exp=1", p_trig); end
    apply(4'h0);
    apply(4'h0);
    checks++; if (s_trig !== 1'b1) begin errors++; $display("FAIL range_hold got=%b exp=1", s_trig); end
    checks++; if (p_trig !== 1'b0) begin errors++; $display("FAIL range_pulse got=%b exp=0", p_trig); end
    clear = 1'b1;
    apply(4'h0);
    clear = 1'b0;
    checks++;
    if (s_trig !== 1'b0 || s_cause !== 4'b0 || s_state !== 4'h0 || s_cnt !== 8'd0) begin
      errors++;
      $display("FAIL range_clear trig=%b cause=%b state=%h cnt=%0d exp all 0",
               s_trig, s_cause, s_state, s_cnt);
    end
  endtask

  task automatic test_dwell();
    do_reset();
    apply(4'h5);
    for (int i = 0; i < 12; i++) apply(4'h6);
    checks++; if (s_trig !== 1'b0) begin errors++; $display("FAIL dwell_12 got=%b exp=0", s_trig); end
    apply(4'h6);
    checks++; if (s_cause !== 4'b0100) begin errors++; $display("FAIL dwell_13 got=%b exp=0100", s_cause); end
    checks++; if (s_state !== 4'h6) begin errors++; $display("FAIL dwell_state got=%h exp=6", s_state); end
  endtask

  task automatic test_dwell_pulse();
    int highs;
    do_reset();
    apply(4'h5);
    highs = 0;
    // Samples 13..15 of WATCH_STATE exceed the limit: three pulses.
    for (int i = 0; i < 15; i++) begin
      apply(4'h6);
      if (p_trig === 1'b1) highs++;
    end
    checks++; if (highs != 3) begin errors++; $display("FAIL pulse_highs got=%0d exp=3", highs); end
    checks++; if (p_cnt !== 8'd3) begin errors++; $display("FAIL pulse_cnt got=%0d exp=3", p_cnt); end
    checks++; if (s_cnt !== 8'd3) begin errors++; $display("FAIL sticky_cnt got=%0d exp=3", s_cnt); end
    clear = 1'b1;
    apply(4'h6);
    clear = 1'b0;
    checks++; if (p_cnt !== 8'd1) begin errors++; $display("FAIL clrfault_pcnt got=%0d exp=1", p_cnt); end
    checks++; if (p_cause !== 4'b0100) begin errors++; $display("FAIL clrfault_pcause got=%b exp=0100", p_cause); end
    checks++; if (s_cnt !== 8'd1) begin errors++; $display("FAIL clrfault_scnt got=%0d exp=1", s_cnt); end
    checks++; if (s_trig !== 1'b1) begin errors++; $display("FAIL clrfault_strig got=%b exp=1", s_trig); end
    apply(4'h0);
    checks++; if (p_trig !== 1'b0) begin errors++; $display("FAIL pulse_exit got=%b exp=0", p_trig); end
  endtask

  task automatic test_sequence();
    logic [3:0] seq [7];
    do_reset();
    seq = '{4'h7, 4'h8, 4'h9, 4'h0, 4'h1, 4'h2, 4'h0};
    foreach (seq[i]) apply(seq[i]);
    checks++;
    if (s_cause !== 4'b0 || s_cnt !== 8'd0) begin
      errors++; $display("FAIL seq_legal cause=%b cnt=%0d exp 0000/0", s_cause, s_cnt);
    end
    apply(4'h1);
    apply(4'h2);
    apply(4'h5);
    checks++; if (s_cause !== 4'b1000) begin errors++; $display("FAIL seq_cause got=%b exp=1000", s_cause); end
    checks++; if (s_state !== 4'h5) begin errors++; $display("FAIL seq_state got=%h exp=5", s_state); end
    // Asynchronous reset mid-cycle returns to reset values immediately.
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (s_trig !== 1'b0 || s_cause !== 4'b0 || s_cnt !== 8'd0) begin
      errors++; $display("FAIL async_reset trig=%b cause=%b cnt=%0d exp 0", s_trig, s_cause, s_cnt);
    end
    @(negedge acq_clk);
    reset_n = 1'b1;
    apply(4'h7);
    checks++; if (s_trig !== 1'b0) begin errors++; $display("FAIL first_after_reset got=%b exp=0", s_trig); end
  endtask

  task automatic test_xz();
    logic [3:0] probe;
    probe = 4'bxx01;
    if ($isunknown(probe)) begin
      do_reset();
      apply(4'h3);
      apply(probe);
      checks++; if (s_cause[1] !== 1'b1) begin errors++; $display("FAIL xz_c1 got=%b exp=1", s_cause[1]); end
      checks++; if (s_cause[3] !== 1'b0) begin errors++; $display("FAIL xz_c3 got=%b exp=0", s_cause[3]); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 260; i++) apply(4'hA);
    checks++; if (s_cnt !== 8'd255) begin errors++; $display("FAIL sat_scnt got=%0d exp=255", s_cnt); end
    checks++; if (p_cnt !== 8'd255) begin errors++; $display("FAIL sat_pcnt got=%0d exp=255", p_cnt); end
    checks++; if (s_cause !== 4'b0001) begin errors++; $display("FAIL sat_cause got=%b exp=0001", s_cause); end
  endtask

  initial begin
    test_reset();
    test_legal_walk();
    test_range();
    test_dwell();
    test_dwell_pulse();
    test_sequence();
    test_xz();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
